fast_command_decoder: RTL and testbench

- Consumes the cleaned serial fast-command bitstream (one bit per sel_fast_clock cycle, MSB of each 8-bit frame first) produced by the fanout/cleanup stage.
- Finds frame alignment from the 3-bit header 110 and the trailing 1 bit, then declares lock and decodes the 4-bit command field into single-cycle command strobes.
- Counts framing errors and drops lock after repeated bad frames. It is the local monitor and consumer of the fanned-out fast-command stream.

---
 rtl/fast_command_decoder.sv | 165 ++++++++++++++++
 tb/tb_fast_command_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fast_command_decoder.sv
// Fast-command stream decoder: finds 8-bit frame alignment on the cleaned
// serial fast-command stream, locks after a run of good frames, decodes the
// command field into single-cycle strobes and keeps error/command counters.
module fast_command_decoder #(
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 3,
  parameter logic [3:0]  IDLE_CODE     = 4'h0,
  parameter bit          INVERT_IN     = 1'b0
) (
  input  logic        sel_fast_clock,
  input  logic        arstn,
  input  logic        fc_in,
  input  logic        clear_counts,
  output logic        locked,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic        frame_err,
  output logic [2:0]  phase,
  output logic [15:0] err_count,
  output logic [15:0] cmd_count
);

  localparam logic [3:0] LOCK_T   = 4'(LOCK_THRESH);
  localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  sr;
  logic [2:0]  bit_ctr;
  logic [2:0]  last_ctr;
  logic [3:0]  good, good_next;
  logic [3:0]  bad, bad_next;
  logic [2:0]  phase_next;
  logic        match;
  logic        slot;
  logic        cmd_hit;
  logic        err_hit;
  logic        code_load;

  // The FSM looks at sr one cycle after the frame's last bit arrived, so
  // last_ctr is the counter value that was current when that bit was
  // sampled; phase records alignment in those terms.
  assign match    = (sr[7:5] == 3'b110) && sr[0];
  assign last_ctr = bit_ctr - 3'd1;
  assign slot     = (last_ctr == phase);

  // Input shift register and free-running bit counter.
  always_ff @(posedge sel_fast_clock or negedge arstn) begin
    if (!arstn) begin
      sr      <= 8'h00;
      bit_ctr <= 3'd0;
    end else begin
      sr      <= {sr[6:0], fc_in ^ INVERT_IN};
      bit_ctr <= bit_ctr + 3'd1;
    end
  end

  // State register together with the alignment bookkeeping it owns.
  always_ff @(posedge sel_fast_clock or negedge arstn) begin
    if (!arstn) begin
      state <= HUNT;
      good  <= 4'd0;
      bad   <= 4'd0;
      phase <= 3'd0;
    end else begin
      state <= state_next;
      good  <= good_next;
      bad   <= bad_next;
      phase <= phase_next;
    end
  end

  // Next-state logic: hunt every cycle, verify and track only on the slot.
  always_comb begin
    state_next = state;
    good_next  = good;
    bad_next   = bad;
    phase_next = phase;
    cmd_hit    = 1'b0;
    err_hit    = 1'b0;
    code_load  = 1'b0;
    case (state)
      HUNT: begin
        if (match) begin
          phase_next = last_ctr;
          good_next  = 4'd1;
          state_next = VERIFY;
        end
      end
      VERIFY: begin
        if (slot) begin
          if (match) begin
            good_next = good + 4'd1;
            if (good + 4'd1 == LOCK_T) begin
              state_next = LOCKED;
              bad_next   = 4'd0;
            end
          end else begin
            state_next = HUNT;
            good_next  = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (slot) begin
          if (match) begin
            bad_next  = 4'd0;
            code_load = 1'b1;
            cmd_hit   = (sr[4:1] != IDLE_CODE);
          end else begin
            err_hit  = 1'b1;
            bad_next = bad + 4'd1;
            if (bad + 4'd1 == UNLOCK_T) begin
              state_next = HUNT;
              good_next  = 4'd0;
            end
          end
        end
      end
      default: begin
        state_next = HUNT;
        good_next  = 4'd0;
        bad_next   = 4'd0;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Registered strobes, command field and counters; clear beats increment.
  always_ff @(posedge sel_fast_clock or negedge arstn) begin
    if (!arstn) begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_code  <= 4'h0;
      err_count <= 16'h0000;
      cmd_count <= 16'h0000;
    end else begin
      cmd_valid <= cmd_hit;
      frame_err <= err_hit;
      if (code_load) begin
        cmd_code <= sr[4:1];
      end
      if (clear_counts) begin
        err_count <= 16'h0000;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
      if (clear_counts) begin
        cmd_count <= 16'h0000;
      end else if (cmd_hit) begin
        cmd_count <= cmd_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fast_command_decoder.sv
// Directed bench for fast_command_decoder. Edge numbers in comments count
// rising edges after arstn release; outputs are sampled on falling edges.
module tb_fast_command_decoder;

  logic        sel_fast_clock;
  logic        arstn;
  logic        fc_in;
  logic        fc_in_inv;
  logic        clear_counts;
  logic        locked, cmd_valid, frame_err;
  logic [3:0]  cmd_code;
  logic [2:0]  phase;
  logic [15:0] err_count, cmd_count;
  logic        inv_locked, inv_cmd_valid, inv_frame_err;
  logic [3:0]  inv_cmd_code;
  logic [2:0]  inv_phase;
  logic [15:0] inv_err_count, inv_cmd_count;

  int checks   = 0;
  int failures = 0;
  int cv_pulses = 0;
  int fe_pulses = 0;
  int fe_before;
  logic both_high = 1'b0;

  assign fc_in_inv = ~fc_in;

  fast_command_decoder dut (
    .sel_fast_clock (sel_fast_clock),
    .arstn          (arstn),
    .fc_in          (fc_in),
    .clear_counts   (clear_counts),
    .locked         (locked),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .frame_err      (frame_err),
    .phase          (phase),
    .err_count      (err_count),
    .cmd_count      (cmd_count)
  );

  fast_command_decoder #(.INVERT_IN(1'b1)) dut_inv (
    .sel_fast_clock (sel_fast_clock),
    .arstn          (arstn),
    .fc_in          (fc_in_inv),
    .clear_counts   (clear_counts),
    .locked         (inv_locked),
    .cmd_valid      (inv_cmd_valid),
    .cmd_code       (inv_cmd_code),
    .frame_err      (inv_frame_err),
    .phase          (inv_phase),
    .err_count      (inv_err_count),
    .cmd_count      (inv_cmd_count)
  );

  // 10-unit clock.
  initial begin
    sel_fast_clock = 1'b0;
    forever #5 sel_fast_clock = ~sel_fast_clock;
  end

  // Strobe tallies and the cmd_valid/frame_err exclusivity flag.
  always @(negedge sel_fast_clock) begin
    if (arstn) begin
      if (cmd_valid) cv_pulses++;
      if (frame_err) fe_pulses++;
      if (cmd_valid && frame_err) both_high = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one bit; it is sampled at the next rising edge, returns on the
  // falling edge after it.
  task automatic applyStimulus(input logic b);
    fc_in = b;
    @(negedge sel_fast_clock);
  endtask

  task automatic sendBits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) applyStimulus(b[i]);
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendBits(b, 7, 0);
  endtask

  initial begin
    arstn        = 1'b0;
    fc_in        = 1'b0;
    clear_counts = 1'b0;
    #12;
    checkOutput("rst_locked", {15'd0, locked}, 16'd0);
    checkOutput("rst_cmd_valid", {15'd0, cmd_valid}, 16'd0);
    checkOutput("rst_frame_err", {15'd0, frame_err}, 16'd0);
    checkOutput("rst_phase", {13'd0, phase}, 16'd0);
    checkOutput("rst_err_count", err_count, 16'd0);
    checkOutput("rst_cmd_count", cmd_count, 16'd0);
    @(negedge sel_fast_clock);
    arstn = 1'b1;

    // Idle from reset: frames end at edges 8,16,24,32.
    sendByte(8'hC1);
    sendBits(8'hC1, 7, 7);                         // edge 9
    checkOutput("idle_phase", {13'd0, phase}, 16'd7);
    sendBits(8'hC1, 6, 0);                         // edge 16
    sendByte(8'hC1);                               // edge 24
    sendByte(8'hC1);                               // edge 32
    checkOutput("idle_locked_e32", {15'd0, locked}, 16'd0);
    sendBits(8'hC1, 7, 7);                         // edge 33
    checkOutput("idle_locked_e33", {15'd0, locked}, 16'd1);
    sendBits(8'hC1, 6, 0);                         // edge 40
    checkOutput("idle_no_cmd", cv_pulses[15:0], 16'd0);
    checkOutput("idle_err_count", err_count, 16'd0);

    // Command 0x2 frame ending at edge 48.
    sendByte(8'hC5);
    checkOutput("cmd_valid_e48", {15'd0, cmd_valid}, 16'd0);
    sendBits(8'hC1, 7, 7);                         // edge 49
    checkOutput("cmd_valid_e49", {15'd0, cmd_valid}, 16'd1);
    checkOutput("cmd_code", {12'd0, cmd_code}, 16'h2);
    checkOutput("cmd_count", cmd_count, 16'd1);
    sendBits(8'hC1, 6, 6);                         // edge 50
    checkOutput("cmd_valid_e50", {15'd0, cmd_valid}, 16'd0);
    sendBits(8'hC1, 5, 0);                         // edge 56

    // One corrupted frame ending at edge 64.
    sendByte(8'h41);
    sendBits(8'hC1, 7, 7);                         // edge 65
    checkOutput("bad1_frame_err", {15'd0, frame_err}, 16'd1);
    checkOutput("bad1_err_count", err_count, 16'd1);
    checkOutput("bad1_locked", {15'd0, locked}, 16'd1);
    sendBits(8'hC1, 6, 0);                         // edge 72

    // Plain count clear on an idle cycle.
    clear_counts = 1'b1;
    sendBits(8'hC1, 7, 7);                         // edge 73
    clear_counts = 1'b0;
    checkOutput("clr_err_count", err_count, 16'd0);
    checkOutput("clr_cmd_count", cmd_count, 16'd0);
    sendBits(8'hC1, 6, 0);                         // edge 80

    // Three bad frames ending 88,96,104; unlock at edge 105.
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    checkOutput("bad3_locked_e104", {15'd0, locked}, 16'd1);
    checkOutput("bad3_err_e104", err_count, 16'd2);
    sendBits(8'hC1, 7, 7);                         // edge 105
    checkOutput("bad3_frame_err", {15'd0, frame_err}, 16'd1);
    checkOutput("bad3_locked_e105", {15'd0, locked}, 16'd0);
    checkOutput("bad3_err_count", err_count, 16'd3);
    sendBits(8'hC1, 6, 0);                         // edge 112
    sendByte(8'hC1);                               // edge 120
    sendByte(8'hC1);                               // edge 128
    sendByte(8'hC1);                               // edge 136
    checkOutput("relock_e136", {15'd0, locked}, 16'd0);
    sendBits(8'hC1, 7, 7);                         // edge 137
    checkOutput("relock_e137", {15'd0, locked}, 16'd1);
    checkOutput("relock_phase", {13'd0, phase}, 16'd7);
    sendBits(8'hC1, 6, 0);                         // edge 144

    // Slip the idle stream by three bits; clear coincides with first error.
    sendBits(8'h00, 2, 0);                         // edges 145..147
    fe_before = fe_pulses;
    sendBits(8'hC1, 7, 3);                         // edges 148..152
    clear_counts = 1'b1;
    sendBits(8'hC1, 2, 2);                         // edge 153
    clear_counts = 1'b0;
    checkOutput("slip_frame_err", {15'd0, frame_err}, 16'd1);
    checkOutput("slip_clear_wins", err_count, 16'd0);
    checkOutput("slip_locked_e153", {15'd0, locked}, 16'd1);
    sendBits(8'hC1, 1, 0);                         // edge 155
    sendByte(8'hC1);                               // edge 163
    sendByte(8'hC1);                               // edge 171
    checkOutput("slip_unlocked", {15'd0, locked}, 16'd0);
    checkOutput("slip_err_count", err_count, 16'd2);
    checkOutput("slip_err_pulses", 16'(fe_pulses - fe_before), 16'd3);
    sendBits(8'hC1, 7, 7);                         // edge 172
    checkOutput("slip_phase", {13'd0, phase}, 16'd2);
    sendBits(8'hC1, 6, 0);                         // edge 179
    sendByte(8'hC1);                               // edge 187
    sendByte(8'hC1);                               // edge 195
    checkOutput("slip_locked_e195", {15'd0, locked}, 16'd0);
    sendBits(8'hC1, 7, 7);                         // edge 196
    checkOutput("slip_locked_e196", {15'd0, locked}, 16'd1);
    sendBits(8'hC1, 6, 0);                         // edge 203
    checkOutput("total_cmd_pulses", cv_pulses[15:0], 16'd1);
    checkOutput("never_both", {15'd0, both_high}, 16'd0);

    // Asynchronous reset in the middle of a frame.
    sendBits(8'hC5, 7, 4);                         // edges 204..207
    #2;
    arstn = 1'b0;
    #1;
    checkOutput("arst_locked", {15'd0, locked}, 16'd0);
    checkOutput("arst_phase", {13'd0, phase}, 16'd0);
    checkOutput("arst_err_count", err_count, 16'd0);
    checkOutput("arst_cmd_code", {12'd0, cmd_code}, 16'd0);
    @(negedge sel_fast_clock);
    arstn = 1'b1;

    // Restart from reset; inverted-input instance must track identically.
    sendByte(8'hC1);
    sendByte(8'hC1);
    sendByte(8'hC1);
    sendByte(8'hC1);                               // edge 32
    checkOutput("restart_locked_e32", {15'd0, locked}, 16'd0);
    checkOutput("inv_locked_e32", {15'd0, inv_locked}, 16'd0);
    sendBits(8'hC1, 7, 7);                         // edge 33
    checkOutput("restart_locked_e33", {15'd0, locked}, 16'd1);
    checkOutput("restart_phase", {13'd0, phase}, 16'd7);
    checkOutput("inv_locked_e33", {15'd0, inv_locked}, 16'd1);
    checkOutput("inv_phase", {13'd0, inv_phase}, 16'd7);
    checkOutput("inv_err_count", inv_err_count, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
